// File: rtl/usb_line_pkg.sv
// Shared constants, FSM state type and byte helpers for the USB line-echo stage.
package usb_line_pkg;

    localparam logic [7:0] CHR_CR  = 8'h0D;
    localparam logic [7:0] CHR_LF  = 8'h0A;
    localparam logic [7:0] CHR_BS  = 8'h08;
    localparam logic [7:0] CHR_DEL = 8'h7F;

    localparam logic [7:0] CHR_LOWER_A = 8'h61;
    localparam logic [7:0] CHR_LOWER_Z = 8'h7A;
    localparam logic [7:0] CASE_OFFSET = 8'h20;

    typedef enum logic [2:0] {
        ST_COLLECT = 3'd0,
        ST_FETCH   = 3'd1,
        ST_SEND    = 3'd2,
        ST_TAIL_CR = 3'd3,
        ST_TAIL_LF = 3'd4
    } state_t;

    // Map ASCII a..z onto A..Z, pass everything else through.
    function automatic logic [7:0] to_upper(input logic [7:0] b);
        if ((b >= CHR_LOWER_A) && (b <= CHR_LOWER_Z)) begin
            return 8'(b - CASE_OFFSET);
        end
        return b;
    endfunction

endpackage

// File: rtl/usb_line_ram.sv
// Line buffer: simple dual-port RAM, one write port and one registered read port (EBR-friendly).
module usb_line_ram #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // No reset on the read register so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/usb_line_echo.sv
// Line-editing echo stage: buffers one received line, replays it plus CR/LF on carriage return.
// Optional build macro USB_LINE_UPCASE_EN stores a..z as upper case.
module usb_line_echo
    import usb_line_pkg::*;
#(
    parameter int unsigned LINE_LEN = 64
) (
    input  logic       clk_48mhz,
    input  logic       reset_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       overflow
);

    localparam int unsigned AW = $clog2(LINE_LEN);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] COUNT_MAX = CW'(LINE_LEN);

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [AW-1:0] rd_q;
    logic [AW-1:0] rd_d;
    logic          in_ready_d;
    logic [7:0]    out_data_d;
    logic          out_valid_d;
    logic          busy_d;
    logic          overflow_d;

    logic          accept_c;
    logic          out_fire_c;
    logic          last_c;
    logic          wr_en_c;
    logic [7:0]    wr_data_c;
    logic [7:0]    rd_data;

    assign accept_c   = in_valid && in_ready;
    assign out_fire_c = out_valid && out_ready;
    assign last_c     = ({1'b0, rd_q} == (count_q - CW'(1)));

`ifdef USB_LINE_UPCASE_EN
    assign wr_data_c = to_upper(in_data);
`else
    assign wr_data_c = in_data;
`endif

    // Read address tracks the next rd so data is ready during FETCH.
    usb_line_ram #(
        .DEPTH (LINE_LEN),
        .AW    (AW)
    ) u_ram (
        .clk     (clk_48mhz),
        .wr_en   (wr_en_c),
        .wr_addr (count_q[AW-1:0]),
        .wr_data (wr_data_c),
        .rd_addr (rd_d),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_COLLECT;
            count_q   <= '0;
            rd_q      <= '0;
            in_ready  <= 1'b0;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rd_q      <= rd_d;
            in_ready  <= in_ready_d;
            out_data  <= out_data_d;
            out_valid <= out_valid_d;
            busy      <= busy_d;
            overflow  <= overflow_d;
        end
    end

    // Next-state, counter and output-register logic.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rd_d        = rd_q;
        out_data_d  = out_data;
        out_valid_d = out_valid;
        overflow_d  = overflow;
        wr_en_c     = 1'b0;

        case (state_q)
            ST_COLLECT: begin
                if (accept_c) begin
                    case (in_data)
                        CHR_CR: begin
                            if (count_q == '0) begin
                                state_d     = ST_TAIL_CR;
                                out_data_d  = CHR_CR;
                                out_valid_d = 1'b1;
                            end else begin
                                rd_d    = '0;
                                state_d = ST_FETCH;
                            end
                        end
                        CHR_LF: begin
                        end
                        CHR_BS, CHR_DEL: begin
                            if (count_q != '0) begin
                                count_d = count_q - CW'(1);
                            end
                        end
                        default: begin
                            if (count_q < COUNT_MAX) begin
                                wr_en_c = 1'b1;
                                count_d = count_q + CW'(1);
                            end else begin
                                overflow_d = 1'b1;
                            end
                        end
                    endcase
                end
            end
            ST_FETCH: begin
                state_d     = ST_SEND;
                out_data_d  = rd_data;
                out_valid_d = 1'b1;
            end
            ST_SEND: begin
                if (out_fire_c) begin
                    if (last_c) begin
                        state_d    = ST_TAIL_CR;
                        out_data_d = CHR_CR;
                    end else begin
                        rd_d        = rd_q + AW'(1);
                        state_d     = ST_FETCH;
                        out_valid_d = 1'b0;
                    end
                end
            end
            ST_TAIL_CR: begin
                if (out_fire_c) begin
                    state_d    = ST_TAIL_LF;
                    out_data_d = CHR_LF;
                end
            end
            ST_TAIL_LF: begin
                if (out_fire_c) begin
                    state_d     = ST_COLLECT;
                    count_d     = '0;
                    rd_d        = '0;
                    overflow_d  = 1'b0;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_COLLECT;
                out_valid_d = 1'b0;
            end
        endcase

        in_ready_d = (state_d == ST_COLLECT);
        busy_d     = (state_d != ST_COLLECT);
    end

endmodule
